mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_ctrl.sv | 105 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select through channels 0..3 and captures z.
// Optional parity output is built when MUX_SCAN_PARITY_EN is defined.
module mux_scan_ctrl #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       z,
    output logic       s1,
    output logic       s0,
    output logic [3:0] sample,
    output logic       valid,
    output logic       busy
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);

    // Last dwell count of a channel; the edge that leaves it is the sample edge.
    localparam logic [3:0] DLAST = 4'(DWELL - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t     state;
    logic [3:0] dcnt;
    logic [1:0] ch;
    logic [3:0] shd;
    logic [3:0] frame;
    logic       last_edge;

    // The channel index is a register, so the select lines are registered too.
    assign {s1, s0} = ch;

    // Word completed by the final sample edge of a frame.
    assign frame = {z, shd[2:0]};

    // High on the edge that samples channel 3.
    assign last_edge = (dcnt == DLAST) && (ch == 2'd3);

    // Scan FSM: dwell counting, channel stepping, capture and frame output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dcnt   <= 4'd0;
            ch     <= 2'd0;
            shd    <= 4'd0;
            sample <= 4'd0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        ch    <= 2'd0;
                        dcnt  <= 4'd0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (dcnt != DLAST) begin
                        dcnt <= dcnt + 4'd1;
                    end else begin
                        shd[ch] <= z;
                        dcnt    <= 4'd0;
                        if (!last_edge) begin
                            ch <= ch + 2'd1;
                        end else begin
                            sample <= frame;
                            valid  <= 1'b1;
                            ch     <= 2'd0;
                            if (!cont) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    // Parity of each published word, updated together with sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (state == SCAN && last_edge) begin
            parity <= ^frame;
        end
    end
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: three DUTs (DWELL 2, 1, 16) around a modelled 4:1 mux,
// compared every cycle against a time-based model of the scan.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] mux_in = 4'd0;

    logic [2:0] s1, s0, valid, busy, par, zz;
    logic [3:0] smp [3];

    int total = 0;
    int bad = 0;

    int   dw  [3];
    int   t   [3];
    bit   act [3];
    logic [3:0] cap [3];
    logic [3:0] es  [3];
    bit   ev  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign zz[g] = mux_in[{s1[g], s0[g]}];
        mux_scan_ctrl #(
            .DWELL(g == 0 ? 2 : (g == 1 ? 1 : 16))
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start),
            .cont   (cont),
            .z      (zz[g]),
            .s1     (s1[g]),
            .s0     (s0[g]),
            .sample (smp[g]),
            .valid  (valid[g]),
            .busy   (busy[g])
`ifdef MUX_SCAN_PARITY_EN
            ,
            .parity (par[g])
`endif
        );
`ifndef MUX_SCAN_PARITY_EN
        assign par[g] = 1'b0;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            act[d] = 0;
            t[d]   = 0;
            cap[d] = 4'd0;
            es[d]  = 4'd0;
            ev[d]  = 0;
        end
    endtask

    // One clock edge of the scan, described by elapsed time since scan start.
    task automatic model_step();
        int k;
        for (int d = 0; d < 3; d++) begin
            ev[d] = 0;
            if (!act[d]) begin
                if (start) begin
                    act[d] = 1;
                    t[d]   = 0;
                end
            end else begin
                t[d]++;
                if (t[d] % dw[d] == 0) begin
                    k = ((t[d] / dw[d]) - 1) % 4;
                    cap[d][k] = mux_in[k];
                    if (t[d] % (4 * dw[d]) == 0) begin
                        es[d] = cap[d];
                        ev[d] = 1;
                        t[d]  = 0;
                        if (!cont) act[d] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        int sel;
        for (int d = 0; d < 3; d++) begin
            sel = act[d] ? (t[d] / dw[d]) % 4 : 0;
            check($sformatf("d%0d sel", d), 32'({s1[d], s0[d]}), 32'(sel));
            check($sformatf("d%0d busy", d), 32'(busy[d]), 32'(act[d]));
            check($sformatf("d%0d valid", d), 32'(valid[d]), 32'(ev[d]));
            check($sformatf("d%0d sample", d), 32'(smp[d]), 32'(es[d]));
`ifdef MUX_SCAN_PARITY_EN
            check($sformatf("d%0d parity", d), 32'(par[d]), 32'(^es[d]));
`endif
        end
    endtask

    task automatic tick(input logic st);
        start = st;
        model_step();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_all();
    endtask

    int vcount;

    initial begin
        dw[0] = 2;
        dw[1] = 1;
        dw[2] = 16;
        model_reset();

        // reset state
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0);

        // single scan 1011, start while busy at E0+3 and at exit edge E0+8
        mux_in = 4'b1011;
        tick(1'b1);
        for (int c = 1; c <= 8; c++) begin
            tick(c == 3 || c == 8);
            if (c == 8) begin
                check("single sample", 32'(smp[0]), 32'h0000000b);
                check("single valid", 32'(valid[0]), 32'd1);
                check("single busy", 32'(busy[0]), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
                check("single parity", 32'(par[0]), 32'd1);
`endif
            end
        end
        for (int c = 0; c < 70; c++) tick(1'b0);

        // DWELL 1 and 16 with 0100
        mux_in = 4'b0100;
        tick(1'b1);
        for (int c = 1; c <= 64; c++) begin
            tick(1'b0);
            if (c == 4) begin
                check("dw1 sample", 32'(smp[1]), 32'h4);
                check("dw1 valid", 32'(valid[1]), 32'd1);
            end
            if (c == 64) begin
                check("dw16 sample", 32'(smp[2]), 32'h4);
                check("dw16 valid", 32'(valid[2]), 32'd1);
            end
        end
        for (int c = 0; c < 4; c++) tick(1'b0);

        // continuous mode, inputs change to 0110 after frame 1
        mux_in = 4'b1011;
        cont = 1'b1;
        tick(1'b1);
        for (int c = 1; c <= 16; c++) begin
            tick(1'b0);
            if (c == 8) begin
                check("cont f1", 32'(smp[0]), 32'hb);
                check("cont gap", 32'(busy[0]), 32'd1);
                mux_in = 4'b0110;
            end
            if (c == 16) begin
                check("cont f2", 32'(smp[0]), 32'h6);
                check("cont v2", 32'(valid[0]), 32'd1);
`ifdef MUX_SCAN_PARITY_EN
                check("cont parity", 32'(par[0]), 32'd0);
`endif
            end
        end
        cont = 1'b0;
        for (int c = 0; c < 70; c++) tick(1'b0);

        // asynchronous reset at E0+5
        mux_in = 4'b1111;
        tick(1'b1);
        for (int c = 1; c <= 4; c++) tick(1'b0);
        model_step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst sel", 32'({s1[0], s0[0]}), 32'd0);
        check("rst busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        for (int c = 0; c < 40; c++) begin
            tick(1'b0);
            vcount += int'(valid[0]) + int'(valid[1]) + int'(valid[2]);
        end
        check("post rst valid", 32'(vcount), 32'd0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            mux_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) cont = ~cont;
            tick($urandom_range(0, 3) == 0);
        end
        cont = 1'b0;
        for (int c = 0; c < 70; c++) tick(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
